prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//
// Loads a program image delivered as a byte stream into a 32-bit wide program
// memory and holds the CPU in reset until the image has loaded (and, with the
// checksum option, been verified).
//
// Stream format (all little-endian):
//   LEN_LO, LEN_HI            : 16-bit word count N
//   4*N data bytes            : words, least significant byte first
//   [CSUM]                    : XOR of all data bytes (checksum build only)
//
// Build option:
//   LOADER_CHECKSUM_EN        : when defined, a trailing checksum byte is
//                               accepted and compared against the XOR of all
//                               data bytes. When undefined, the loader
//                               finishes straight after the last data byte.
//
// Parameters:
//   BASE_WORD  word index of the first word written
//   MAX_WORDS  largest accepted image length in words
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous, active-low reset
//   in_valid   a byte is offered on in_data
//   in_data    image byte
//   in_ready   loader accepts a byte this cycle
//   mem_we     one-cycle word write strobe
//   mem_addr   word index of the write
//   mem_wdata  word to write
//   cpu_rst    active-high reset held on the CPU until the load completes
//   done       image loaded (and verified)
//   err        load failed (length too large or checksum mismatch)
// -----------------------------------------------------------------------------
module prog_loader #(
  parameter int BASE_WORD = 0,
  parameter int MAX_WORDS = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [8:0]  mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_rst,
  output logic        done,
  output logic        err
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    LEN_LO = 3'd0,
    LEN_HI = 3'd1,
    DATA   = 3'd2,
    CSUM   = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_e;
  // State entered once the data phase (or an empty image) is finished.
  localparam state_e POST_DATA = CSUM;
`else
  typedef enum logic [2:0] {
    LEN_LO = 3'd0,
    LEN_HI = 3'd1,
    DATA   = 3'd2,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_e;
  localparam state_e POST_DATA = DONE;
`endif

  // Length limit widened by one bit so a 16-bit count can never wrap the compare.
  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);
  localparam logic [8:0]  BASE_ADDR = 9'(BASE_WORD);

  state_e state_q, state_d;

  logic [7:0]  len_lo_q,   len_lo_d;
  logic [15:0] n_q,        n_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic [23:0] asm_q,      asm_d;
  logic        we_q,       we_d;
  logic [8:0]  addr_q,     addr_d;
  logic [31:0] wdata_q,    wdata_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum_q,     csum_d;
`endif

  logic        accept;
  logic [15:0] len_n;
  logic        last_byte;
  logic        last_word;
  logic [8:0]  word_addr;

  assign accept    = in_valid & in_ready;
  assign len_n     = {in_data, len_lo_q};
  assign last_byte = (byte_cnt_q == 2'd3);
  assign last_word = ((word_cnt_q + 16'd1) == n_q);
  assign word_addr = BASE_ADDR + word_cnt_q[8:0];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= LEN_LO;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      LEN_LO: begin
        if (accept) state_d = LEN_HI;
      end
      LEN_HI: begin
        if (accept) begin
          if ({1'b0, len_n} > MAX_LEN) begin
            state_d = ERR;
          end else if (len_n == 16'd0) begin
            state_d = POST_DATA;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept && last_byte && last_word) state_d = POST_DATA;
      end
`ifdef LOADER_CHECKSUM_EN
      CSUM: begin
        if (accept) state_d = (in_data == csum_q) ? DONE : ERR;
      end
`endif
      DONE: state_d = DONE;
      ERR:  state_d = ERR;
      // An unreachable encoding must never release the CPU.
      default: state_d = ERR;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (pure decode of the current state)
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready = 1'b0;
    cpu_rst  = 1'b1;
    done     = 1'b0;
    err      = 1'b0;
    case (state_q)
      LEN_LO, LEN_HI, DATA: in_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      CSUM: in_ready = 1'b1;
`endif
      DONE: begin
        cpu_rst = 1'b0;
        done    = 1'b1;
      end
      ERR: err = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: length capture, word assembly, write strobe, checksum
  // ---------------------------------------------------------------------------
  always_comb begin
    len_lo_d   = len_lo_q;
    n_d        = n_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    asm_d      = asm_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    if (accept) begin
      case (state_q)
        LEN_LO: len_lo_d = in_data;
        LEN_HI: begin
          n_d        = len_n;
          byte_cnt_d = 2'd0;
          word_cnt_d = 16'd0;
        end
        DATA: begin
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q ^ in_data;
`endif
          case (byte_cnt_q)
            2'd0: asm_d[7:0]   = in_data;
            2'd1: asm_d[15:8]  = in_data;
            2'd2: asm_d[23:16] = in_data;
            default: begin
              // Fourth byte completes the word; the strobe is registered so it
              // appears in the following cycle with the full word.
              we_d       = 1'b1;
              addr_d     = word_addr;
              wdata_d    = {in_data, asm_q};
              word_cnt_d = word_cnt_q + 16'd1;
            end
          endcase
          byte_cnt_d = byte_cnt_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      len_lo_q   <= '0;
      n_q        <= '0;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      asm_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      len_lo_q   <= len_lo_d;
      n_q        <= n_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      asm_q      <= asm_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule
